// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the multi-cycle divide/remainder sequencer.
//   - ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU : 5-bit opcodes accepted by div_seq.
//     Their values mirror the execute-stage opcode map.
//   - op_info_t / decode_op : turns an opcode into supported/signed/remainder flags.
package div_seq_pkg;

    localparam logic [4:0] ALU_DIV  = 5'h0C;
    localparam logic [4:0] ALU_DIVU = 5'h0D;
    localparam logic [4:0] ALU_REM  = 5'h0E;
    localparam logic [4:0] ALU_REMU = 5'h0F;

    typedef struct packed {
        logic supported;
        logic is_signed;
        logic sel_rem;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t info;
        info = '0;
        case (op)
            ALU_DIV:  info = '{supported: 1'b1, is_signed: 1'b1, sel_rem: 1'b0};
            ALU_DIVU: info = '{supported: 1'b1, is_signed: 1'b0, sel_rem: 1'b0};
            ALU_REM:  info = '{supported: 1'b1, is_signed: 1'b1, sel_rem: 1'b1};
            ALU_REMU: info = '{supported: 1'b1, is_signed: 1'b0, sel_rem: 1'b1};
            default:  info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if
// Request/response handshake bundle between the execute stage and div_seq.
//   Request : in_valid, in_ready, opcode, rs1 (dividend), rs2 (divisor)
//   Response: out_valid, out_ready, rd (result)
//   master : the pipeline side that issues operations and consumes results
//   slave  : the divider side
interface div_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      opcode;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;

    modport master (
        output in_valid, opcode, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd
    );

    modport slave (
        input  in_valid, opcode, rs1, rs2, out_ready,
        output in_ready, out_valid, rd
    );
endinterface

// File: rtl/div_seq_step.sv
// div_step
// One radix-2 restoring division iteration, purely combinational.
//   rem_i     : partial remainder (always < divisor_i)
//   quo_i     : partial quotient; its MSB is the next dividend bit to shift in
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quo_o     : next partial quotient with the new quotient bit in the LSB
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The shifted remainder needs XLEN+1 bits because rem_i can be up to
    // divisor-1 before doubling; the trial difference then fits in XLEN+1
    // bits signed, so its MSB is the "went negative" flag.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[XLEN]) begin
            rem_o = trial[XLEN-1:0];
        end else begin
            rem_o = shifted[XLEN-1:0];
        end
        quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};
    end
endmodule

// File: rtl/div_seq.sv
// div_seq
// Multi-cycle DIV/DIVU/REM/REMU sequencer: one quotient bit per cycle using
// restoring division, with RISC-V special cases resolved at acceptance.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   flush : abort the operation in flight; rd is preserved
//   bus   : div_seq_if.slave (in_valid/in_ready/opcode/rs1/rs2, out_valid/out_ready/rd)
//   busy  : high whenever the sequencer is not idle
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    div_seq_if.slave  bus,
    output logic      busy
);
    import div_seq_pkg::*;

    localparam int CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            sel_rem_q, sel_rem_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rd_q, rd_d;

    op_info_t        info;
    logic            accept;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] quo_fix, rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.rd        = rd_q;
    assign busy          = (state_q != IDLE);

    // Next-state logic. Fast-path results are decided from the raw operands
    // at acceptance; normal operations iterate on operand magnitudes and the
    // signs are restored on the last step. Flush overrides everything except
    // rd, which keeps its last value.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        sel_rem_d   = sel_rem_q;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;

        info    = decode_op(bus.opcode);
        accept  = bus.in_valid && (state_q == IDLE) && !flush;
        rs1_neg = info.is_signed && bus.rs1[XLEN-1];
        rs2_neg = info.is_signed && bus.rs2[XLEN-1];
        rs1_abs = rs1_neg ? -bus.rs1 : bus.rs1;
        rs2_abs = rs2_neg ? -bus.rs2 : bus.rs2;
        quo_fix = q_neg_q ? -step_quo : step_quo;
        rem_fix = r_neg_q ? -step_rem : step_rem;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_rem_d = info.sel_rem;
                    if (!info.supported) begin
                        rd_d        = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (bus.rs2 == '0) begin
                        rd_d        = info.sel_rem ? bus.rs1 : '1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (info.is_signed && (bus.rs1 == MOST_NEG) && (bus.rs2 == '1)) begin
                        rd_d        = info.sel_rem ? '0 : bus.rs1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = rs1_abs;
                        dvs_d   = rs2_abs;
                        cnt_d   = CNT_LAST;
                        q_neg_d = rs1_neg ^ rs2_neg;
                        r_neg_d = rs1_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    rd_d        = sel_rem_q ? rem_fix : quo_fix;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    // All sequencer state, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            sel_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            sel_rem_q   <= sel_rem_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq
// Directed, table-driven bench for div_seq (XLEN=32) with hand-written
// sequences for flush, reset during iteration and back-pressure.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int assertions = 0;
    int failures   = 0;

    div_seq_if #(.XLEN(XLEN)) bus();

    div_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rd;
        int         exp_lat;
        int         hold;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer one operation; returns right after the accepting rising edge.
    task automatic applyStimulus(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.rs1      = a;
        bus.rs2      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts rising edges after acceptance until out_valid is seen, bounded.
    task automatic waitResult(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n;
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v.name, v.op, v.a, v.b);
        waitResult(lat);
        checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({v.name, "_rd"}, bus.rd, v.exp_rd);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({v.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({v.name, "_hold_rd"}, bus.rd, v.exp_rd);
            checkOutput({v.name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput({v.name, "_released_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({v.name, "_released_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int saw_valid;
        int lat;

        vecs.push_back('{"div_m7_2",      ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 1});
        vecs.push_back('{"rem_m7_2",      ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0});
        vecs.push_back('{"bad_opcode",    5'h1F,    32'd50,        32'd5,         32'h0000_0000,  0, 0});
        vecs.push_back('{"divu_big",      ALU_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32, 5});
        vecs.push_back('{"remu_big",      ALU_REMU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32, 0});
        vecs.push_back('{"div_by_zero",   ALU_DIV,  32'h1234,      32'd0,         32'hFFFF_FFFF,  0, 2});
        vecs.push_back('{"remu_by_zero",  ALU_REMU, 32'h1234,      32'd0,         32'h0000_1234,  0, 0});
        vecs.push_back('{"div_ovf",       ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  0, 0});
        vecs.push_back('{"rem_ovf",       ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,  0, 0});
        vecs.push_back('{"divu_no_ovf",   ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32, 0});
        vecs.push_back('{"remu_no_ovf",   ALU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0});
        vecs.push_back('{"div_min_2",     ALU_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 32, 0});
        vecs.push_back('{"div_min_3",     ALU_DIV,  32'h8000_0000, 32'd3,         32'hD555_5556, 32, 0});
        vecs.push_back('{"rem_min_3",     ALU_REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 32, 0});
        vecs.push_back('{"div_7_m2",      ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 0});
        vecs.push_back('{"rem_7_m2",      ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32, 0});
        vecs.push_back('{"divu_0_5",      ALU_DIVU, 32'd0,         32'd5,         32'h0000_0000, 32, 0});

        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_rd", bus.rd, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) runVector(vecs[i]);

        // Flush on the 10th edge after acceptance: no result may ever appear.
        applyStimulus("flush_div", ALU_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        saw_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1;
        end
        checkOutput("flush_no_pulse", 32'(saw_valid), 32'd0);
        runVector('{"divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32, 0});

        // Flush together with in_valid in IDLE: the op is dropped.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = ALU_DIV;
        bus.rs1      = 32'd9;
        bus.rs2      = 32'd0;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        checkOutput("flush_accept_busy", 32'(busy), 32'd0);
        checkOutput("flush_accept_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_accept_rd", bus.rd, 32'd14);

        // Flush while a result waits in DONE: out_valid drops, rd is kept.
        applyStimulus("flush_done", ALU_DIV, 32'h55, 32'd0);
        waitResult(lat);
        checkOutput("flush_done_latency", 32'(lat), 32'd0);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("flush_done_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_done_rd", bus.rd, 32'hFFFF_FFFF);
        checkOutput("flush_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset during iteration.
        applyStimulus("reset_calc", ALU_DIV, 32'd500, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_calc_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_calc_busy", 32'(busy), 32'd0);
        checkOutput("rst_calc_rd", bus.rd, 32'd0);
        checkOutput("rst_calc_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        saw_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1;
        end
        checkOutput("rst_calc_no_pulse", 32'(saw_valid), 32'd0);

        runVector('{"div_after_rst", ALU_DIV, 32'd500, 32'd7, 32'd71, 32, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the M-extension divide/remainder unit; replaces the single-cycle combinational divider on the execute stage.
- Accepts one DIV/DIVU/REM/REMU operation through a valid/ready handshake and runs a radix-2 restoring division, one quotient bit per cycle.
- Resolves RISC-V special cases in a fast path and returns the result through a valid/ready handshake.
- Pipeline stalls on in_ready / out_valid; flush kills the operation in flight.

Parameters:
- XLEN, 32, operand and result width; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  abort the in-flight operation (branch mispredict or trap)
- in_valid  in  1  operation offered
- in_ready  out  1  sequencer can accept; equals (state==IDLE)
- opcode  in  5  `ALU_DIV / `ALU_DIVU / `ALU_REM / `ALU_REMU; any other code yields 0
- rs1  in  XLEN  dividend
- rs2  in  XLEN  divisor
- out_valid  out  1  rd holds a result
- out_ready  in  1  consumer takes the result
- rd  out  XLEN  result; stable while out_valid && !out_ready
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, out_valid=0, rd=0, busy=0, in_ready=1, counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready at edge T latches opcode, operands, signedness (DIV/REM) and result selection (REM/REMU = remainder).
- Fast path, decided at acceptance from raw operands; IDLE→DONE, out_valid at T+1:
  - rs2==0: quotient ops → all-ones; remainder ops → rs1.
  - Signed overflow (rs1 == 1<<(XLEN-1), rs2 == all-ones): DIV → rs1; REM → 0.
  - Unsupported opcode → 0.
- Normal path: IDLE→CALC.
  - Latch absolute values for signed ops; record quotient sign = sign(rs1)^sign(rs2) and remainder sign = sign(rs1).
  - Counter loads XLEN-1.
- CALC, each cycle:
  - Shift {rem, quo} left 1, bringing in the next dividend bit.
  - Trial subtract divisor (XLEN+1-bit arithmetic); if non-negative, keep the difference and set the quotient LSB to 1.
  - Counter decrements; when counter==0 after the step, go to DONE.
  - Exactly XLEN CALC cycles, so out_valid rises at T+XLEN+1.
- Sign fix on entry to DONE: negate quotient if quotient sign=1; negate remainder if remainder sign=1 (two's complement, XLEN bits). rd gets the selected value.
- DONE:
  - out_valid=1; hold rd and out_valid until out_ready.
  - out_valid && out_ready at an edge → IDLE; out_valid=0 the next cycle.
  - No new op is accepted in the same cycle (in_ready=0 in DONE).
- flush:
  - From any state, the next state is IDLE and out_valid=0 next cycle; rd keeps its value.
  - flush has priority over accept and over out_ready.
  - flush && in_valid in IDLE: the op is not accepted.
- Reset mid-operation: same as the reset state above; no result emitted.
- Unsigned ops use rs1/rs2 as-is. Quotient of the most-negative dividend by a non-(-1) divisor is handled by the XLEN-bit absolute value, since magnitude 2^(XLEN-1) fits unsigned.

Decomposition:
- Opcode constants (`ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU) come from the shared defines.vh.
- State encodings (IDLE/CALC/DONE) are localparams inside div_seq.
- One combinational sub-module, div_step: inputs partial remainder, partial quotient, divisor; outputs the next remainder and quotient for one restoring iteration. div_seq owns all registers, handshake and sign logic.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → out_valid at T+33, rd=0xFFFFFFFD (-3); REM same operands → rd=0xFFFFFFFF (-1).
- DIVU rs1=0xFFFFFFFF, rs2=0x10 → rd=0x0FFFFFFF; REMU → rd=0x0000000F; out_ready held low 5 cycles → rd and out_valid stable throughout.
- Divide by zero: DIV rs1=0x1234 → rd=0xFFFFFFFF at T+1; REMU rs1=0x1234, rs2=0 → rd=0x1234 at T+1.
- Overflow: DIV rs1=0x80000000, rs2=0xFFFFFFFF → rd=0x80000000 at T+1; REM same → rd=0 at T+1.
- flush asserted at T+10 of a normal DIV → IDLE next cycle, in_ready=1, no out_valid pulse; a following DIVU 100/7 → rd=14.
- rst_n low during CALC → next cycle out_valid=0, busy=0, rd=0, in_ready=1; unknown opcode 5'h1F with in_valid → rd=0 at T+1.
